tcom_pulse_gen: RTL

Parametrised multi-channel strobe generator for the imitator and time-scale (TCOM) subsystem. It replaces the free-running 10-bit wrap counter that drives `fix_pulse`. Each of `N_CH` channels emits single-cycle pulses with programmable period, phase offset and mode (periodic, one-shot, burst). Outputs feed `fix_pulse`/`irq_pulse` of the imitator and the TCOM scales.

---
 rtl/tcom_pulse_gen.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/tcom_pulse_gen.sv
// Multi-channel strobe generator: per-channel periodic / one-shot / burst pulses with shadowed config.
// Optional sync_in realignment is built when PULSE_GEN_SYNC_EN is defined.
module tcom_pulse_gen #(
  parameter int N_CH  = 6,
  parameter int CNT_W = 10,
  parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_phase,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic [N_CH-1:0]  start,
  input  logic [N_CH-1:0]  stop,
  input  logic             sync_in,
  output logic [N_CH-1:0]  pulse,
  output logic [N_CH-1:0]  busy,
  output logic [N_CH-1:0]  done
);

  typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, RUN = 2'd2} state_t;

`ifdef PULSE_GEN_SYNC_EN
  logic sync_p0, sync_p1, sync_p2, realign_p3;

  // synchroniser p0/p1, edge history p2, registered rising edge p3
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_p0    <= 1'b0;
      sync_p1    <= 1'b0;
      sync_p2    <= 1'b0;
      realign_p3 <= 1'b0;
    end else begin
      sync_p0    <= sync_in;
      sync_p1    <= sync_p0;
      sync_p2    <= sync_p1;
      realign_p3 <= sync_p1 & ~sync_p2;
    end
  end
`else
  logic unused_sync;
  assign unused_sync = sync_in;
`endif

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, left_q, left_d;
    logic [CNT_W-1:0] sh_period_q, sh_phase_q, sh_count_q;
    logic [1:0]       sh_mode_q;
    logic [CNT_W-1:0] nx_period, nx_phase, nx_count;
    logic [1:0]       nx_mode;
    logic [CNT_W-1:0] act_phase_q;
    logic [1:0]       act_mode_q;
    logic             wr, load, pulse_d, done_d;
    logic             pulse_q, done_q, busy_q;

    // A write landing on the copy edge must be the value transferred, so copies read through the write port.
    // Active period/count are consumed at copy time directly into cnt/left.
    assign wr        = cfg_we && (cfg_ch == CH_W'(g));
    assign nx_period = wr ? cfg_period : sh_period_q;
    assign nx_phase  = wr ? cfg_phase  : sh_phase_q;
    assign nx_count  = wr ? cfg_count  : sh_count_q;
    assign nx_mode   = wr ? cfg_mode   : sh_mode_q;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      left_d  = left_q;
      load    = 1'b0;
      pulse_d = 1'b0;
      done_d  = 1'b0;
      case (state_q)
        IDLE: begin
          if (start[g]) begin
            load    = 1'b1;
            cnt_d   = nx_phase;
            left_d  = (nx_count == '0) ? CNT_W'(1) : nx_count;
            state_d = DELAY;
          end
        end
        DELAY, RUN: begin
          if (cnt_q == '0) begin
            pulse_d = 1'b1;
            load    = 1'b1;
            cnt_d   = nx_period;
            state_d = RUN;
            if (act_mode_q == 2'd1) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else if (act_mode_q == 2'd2) begin
              left_d = left_q - CNT_W'(1);
              if (left_q <= CNT_W'(1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
`ifdef PULSE_GEN_SYNC_EN
      if (realign_p3 && (state_q != IDLE)) begin
        state_d = DELAY;
        cnt_d   = act_phase_q;
        left_d  = left_q;
        load    = 1'b0;
        pulse_d = 1'b0;
        done_d  = 1'b0;
      end
`endif
      if (stop[g]) begin
        state_d = IDLE;
        cnt_d   = cnt_q;
        left_d  = left_q;
        load    = 1'b0;
        pulse_d = 1'b0;
        done_d  = 1'b0;
      end
    end

`ifndef PULSE_GEN_SYNC_EN
    logic unused_phase;
    assign unused_phase = ^act_phase_q;
`endif

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        state_q     <= IDLE;
        cnt_q       <= '0;
        left_q      <= '0;
        sh_period_q <= '0;
        sh_phase_q  <= '0;
        sh_count_q  <= '0;
        sh_mode_q   <= '0;
        act_phase_q <= '0;
        act_mode_q  <= '0;
        pulse_q     <= 1'b0;
        done_q      <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        left_q  <= left_d;
        pulse_q <= pulse_d;
        done_q  <= done_d;
        busy_q  <= (state_d != IDLE);
        if (wr) begin
          sh_period_q <= cfg_period;
          sh_phase_q  <= cfg_phase;
          sh_count_q  <= cfg_count;
          sh_mode_q   <= cfg_mode;
        end
        if (load) begin
          act_phase_q <= nx_phase;
          act_mode_q  <= nx_mode;
        end
      end
    end

    assign pulse[g] = pulse_q;
    assign done[g]  = done_q;
    assign busy[g]  = busy_q;
  end

endmodule
